// File: rtl/pc_word_router_if.sv
// pc_word_router_if: valid/data/ack channel bundle.
// N parallel lanes share one bundle so that a channel array travels as one port.
interface pc_word_router_if #(
    parameter int W = 24,
    parameter int N = 1
);
    logic [N-1:0]        v;
    logic [N-1:0][W-1:0] d;
    logic [N-1:0]        a;

    modport master (output v, d, input a);
    modport slave  (input v, d, output a);
endinterface

// File: rtl/pc_word_router.sv
// pc_word_router: decodes raw PC link words by opcode and routes each one to
// the BD passthrough, the config register file or a config channel, through
// a single-word stage. Malformed/out-of-range words are dropped and counted.
module pc_word_router #(
    parameter int NPCin   = 24,
    parameter int NBDdata = 21,
    parameter int Nconf   = 16,
    parameter int Nreg    = 32,
    parameter int Nchan   = 2,
    parameter int Ndrop   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_word_router_if.slave       PC_in,
    pc_word_router_if.master      BD_data_out,
    pc_word_router_if.master      conf_channel_out,
    input  logic [Nreg*Nconf-1:0] conf_reg_reset_vals,
    output logic [Nreg*Nconf-1:0] conf_reg_out,
    output logic [Ndrop-1:0]      drop_count
);
    localparam int IDX_LO = 16;
    localparam int IDX_W  = 5;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_HOLD} state_t;
    typedef enum logic [1:0] {K_BD, K_REG, K_CHAN, K_DROP} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_in, kind_p0;
    logic [NPCin-1:0]   word;
    logic [IDX_W-1:0]   idx_in, idx_p0;
    logic [Nconf-1:0]   data_p0;
    logic [NBDdata-1:0] bd_p0;
    logic               vld_p0, drain, load, accept_rdy;
    logic               reg_we, drop_inc, chan_ack;
    logic [Nchan-1:0]   chan_v;
    logic               unused_pc_bit;

    function automatic logic [Ndrop-1:0] sat_inc(input logic [Ndrop-1:0] x);
        return (&x) ? x : x + Ndrop'(1);
    endfunction

    assign word          = PC_in.d[0];
    assign idx_in        = word[IDX_LO +: IDX_W];
    assign unused_pc_bit = word[NBDdata];
    assign vld_p0        = (state_q == ST_HOLD);

    // Classify the incoming word; anything not routable becomes a drop.
    always_comb begin
        kind_in = K_DROP;
        case (word[NPCin-1 -: 2])
            2'b00: kind_in = K_BD;
            2'b01: if (int'(idx_in) < Nreg)  kind_in = K_REG;
            2'b10: if (int'(idx_in) < Nchan) kind_in = K_CHAN;
            default: kind_in = K_DROP;
        endcase
    end

    // State register; reset discards whatever the stage held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Stage drain, upstream ready and next state. Ready only sees the sink
    // acks through the drain term so a word can enter as the previous leaves.
    always_comb begin
        state_d    = state_q;
        drain      = 1'b0;
        reg_we     = 1'b0;
        drop_inc   = 1'b0;
        chan_ack   = |(conf_channel_out.a & chan_v);
        if (vld_p0) begin
            case (kind_p0)
                K_BD:    drain = BD_data_out.a[0];
                K_CHAN:  drain = chan_ack;
                K_REG:   begin drain = 1'b1; reg_we   = 1'b1; end
                default: begin drain = 1'b1; drop_inc = 1'b1; end
            endcase
        end
        accept_rdy = (state_q != ST_INIT) && (!vld_p0 || drain);
        load       = PC_in.v[0] && accept_rdy;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: if (load) state_d = ST_HOLD;
            ST_HOLD: if (drain && !load) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    assign PC_in.a[0] = accept_rdy;

    // ---- stage p0: decoded word captured on accept ----
    always_ff @(posedge clk) begin
        if (load) begin
            kind_p0 <= kind_in;
            idx_p0  <= idx_in;
            data_p0 <= word[Nconf-1:0];
            bd_p0   <= word[NBDdata-1:0];
        end
    end

    // Downstream valids come straight from the stage; only one sink is ever offered a word.
    always_comb begin
        BD_data_out.v[0] = vld_p0 && (kind_p0 == K_BD);
        BD_data_out.d[0] = bd_p0;
        for (int i = 0; i < Nchan; i++) begin
            chan_v[i]             = vld_p0 && (kind_p0 == K_CHAN) && (int'(idx_p0) == i);
            conf_channel_out.d[i] = data_p0;
        end
        conf_channel_out.v = chan_v;
    end

    // Register file: cleared by reset, loaded from reset values on the INIT edge, then single-register writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  conf_reg_out <= '0;
        else if (state_q == ST_INIT) conf_reg_out <= conf_reg_reset_vals;
        else if (reg_we)            conf_reg_out[int'(idx_p0)*Nconf +: Nconf] <= data_p0;
    end

    // Saturating count of dropped words, bumped as a dropped word leaves the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         drop_count <= '0;
        else if (drop_inc) drop_count <= sat_inc(drop_count);
    end
endmodule
